// File: rtl/turf_trig_source_arbiter_if.sv
// Register-side bundle for the TURF trigger-source arbiter.
// master: register interface / trigger consumer side that drives the controls.
// slave : the arbiter itself.
interface turf_trig_source_arbiter_if #(
    parameter int N_SRC     = 4,
    parameter int HOLDOFF_W = 16,
    parameter int CNT_W     = 32
);
    logic [N_SRC-1:0]     trig_i;
    logic [N_SRC-1:0]     en_i;
    logic                 disable_i;
    logic                 busy_i;
    logic [HOLDOFF_W-1:0] holdoff_i;
    logic                 clr_i;
    logic [3:0]           cnt_sel_i;
    logic                 trig_o;
    logic [N_SRC-1:0]     trig_src_o;
    logic                 lost_o;
    logic [CNT_W-1:0]     cnt_o;
    logic [1:0]           state_o;

    modport master (
        output trig_i, en_i, disable_i, busy_i, holdoff_i, clr_i, cnt_sel_i,
        input  trig_o, trig_src_o, lost_o, cnt_o, state_o
    );

    modport slave (
        input  trig_i, en_i, disable_i, busy_i, holdoff_i, clr_i, cnt_sel_i,
        output trig_o, trig_src_o, lost_o, cnt_o, state_o
    );
endinterface

// File: rtl/turf_trig_source_arbiter.sv
// TURF trigger-source arbiter (CLK33 register domain).
// Combines N_SRC enable-masked trigger levels into a single accepted-trigger
// pulse with rising-edge qualification, busy/disable gating, a programmable
// holdoff, per-source accept counters and a saturating lost-trigger counter.
//
// Optional build macro TRIG_SRC_PRIORITY_EN: when defined, a simultaneous
// accept reports (and counts) only the lowest-index source; otherwise the
// full edge mask is reported and every source in it is counted.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an enabled edge; busy/disable gate checked here
// FIRE  | trig_o high for this single cycle; holdoff counter loaded
// HOLDOFF| dead time; counter decrements, exits on the cycle it reads 1
// RSVD  | unused encoding, recovers to IDLE on the next clock
module turf_trig_source_arbiter #(
    parameter int N_SRC     = 4,
    parameter int HOLDOFF_W = 16,
    parameter int CNT_W     = 32
) (
    input  logic clk_i,
    input  logic rst_n_i,
    turf_trig_source_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_RSVD    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [N_SRC-1:0]     trig_q;
    logic [N_SRC-1:0]     edge_q;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic [N_SRC-1:0]     src_q, src_d;
    logic                 lost_q, lost_d;
    logic                 accept;
    logic                 any_edge;
    logic [N_SRC-1:0]     accept_mask;
    logic [CNT_W-1:0]     src_cnt_q [N_SRC];
    logic [CNT_W-1:0]     lost_cnt_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // The enable is applied when the edge is captured, so a source masked at
    // the moment it rises cannot fire later while its level stays high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_q <= '0;
            edge_q <= '0;
        end else begin
            trig_q <= bus.trig_i;
            edge_q <= bus.trig_i & ~trig_q & bus.en_i;
        end
    end

    assign any_edge = |edge_q;

`ifdef TRIG_SRC_PRIORITY_EN
    // Isolate the lowest set bit: lowest source ID wins a simultaneous accept.
    assign accept_mask = edge_q & (~edge_q + N_SRC'(1));
`else
    assign accept_mask = edge_q;
`endif

    // FSM state, holdoff counter, latched source mask and lost pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            src_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            src_q   <= src_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state logic: gate only in IDLE, every edge outside IDLE is lost.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        src_d   = src_q;
        lost_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_edge) begin
                    if (!bus.disable_i && !bus.busy_i) begin
                        accept  = 1'b1;
                        src_d   = accept_mask;
                        state_d = ST_FIRE;
                    end else begin
                        lost_d = 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                // holdoff_i is sampled only here; later changes are ignored.
                hold_d  = bus.holdoff_i;
                state_d = (bus.holdoff_i != '0) ? ST_HOLDOFF : ST_IDLE;
                lost_d  = any_edge;
            end
            ST_HOLDOFF: begin
                hold_d = hold_q - HOLDOFF_W'(1);
                // Leaving on the cycle the count reads 1 gives exactly
                // holdoff_i dead cycles after FIRE.
                if (hold_q <= HOLDOFF_W'(1)) begin
                    state_d = ST_IDLE;
                end
                lost_d = any_edge;
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Accept and lost counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < N_SRC; k++) begin
                src_cnt_q[k] <= '0;
            end
            lost_cnt_q <= '0;
        end else if (bus.clr_i) begin
            for (int k = 0; k < N_SRC; k++) begin
                src_cnt_q[k] <= '0;
            end
            lost_cnt_q <= '0;
        end else begin
            for (int k = 0; k < N_SRC; k++) begin
                if (accept && accept_mask[k]) begin
                    src_cnt_q[k] <= src_cnt_q[k] + CNT_W'(1);
                end
            end
            // Once per rejection cycle regardless of how many sources edged.
            if (lost_d && (lost_cnt_q != '1)) begin
                lost_cnt_q <= lost_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter read mux; codes with no counter behind them read 0.
    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (bus.cnt_sel_i == 4'(k)) begin
                cnt_d = src_cnt_q[k];
            end
        end
        if (bus.cnt_sel_i == 4'hF) begin
            cnt_d = lost_cnt_q;
        end
    end

    // Registered readback of the selected counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.trig_o     = (state_q == ST_FIRE);
    assign bus.trig_src_o = src_q;
    assign bus.lost_o     = lost_q;
    assign bus.cnt_o      = cnt_q;
    assign bus.state_o    = state_q;

endmodule

// File: doc/turf_trig_source_arbiter.md
Name: turf_trig_source_arbiter

Overview:
Parametrised trigger-source combiner for the TURF. It replaces the fixed "soft OR external" trigger gating with N_SRC enable-masked sources, such as soft, external, PPS1 and PPS2. It adds rising-edge qualification, a programmable holdoff, busy/disable gating, per-source accepted counters and a lost-trigger counter. It sits between the register interface and the trigger interface, in the 33 MHz register clock domain.

Parameters:
N_SRC, 4, number of trigger sources (1..8); bit index is the source ID.
HOLDOFF_W, 16, width of the holdoff counter and of holdoff_i.
CNT_W, 32, width of the per-source counters and the lost counter.

Ports:
clk_i  input  1  system clock (CLK33 domain).
rst_n_i  input  1  asynchronous active-low reset.
trig_i  input  N_SRC  trigger levels; already synchronous to clk_i.
en_i  input  N_SRC  per-source enable mask.
disable_i  input  1  master trigger disable.
busy_i  input  1  downstream cannot accept (buffers full).
holdoff_i  input  HOLDOFF_W  dead time after an accept, in clk_i cycles.
clr_i  input  1  synchronous clear of all counters.
cnt_sel_i  input  4  counter select: 0..N_SRC-1 = per-source; 15 = lost; other values read 0.
trig_o  output  1  one-cycle accepted-trigger pulse.
trig_src_o  output  N_SRC  source mask, valid while trig_o=1; holds its value until the next accept.
lost_o  output  1  one-cycle pulse when an enabled edge is rejected.
cnt_o  output  CNT_W  selected counter, registered (1 cycle after cnt_sel_i changes).
state_o  output  2  FSM state, for debug.

Behaviour:
- Reset (rst_n_i=0, asynchronous): all outputs 0, state IDLE, all counters 0, edge registers 0.
- Edge detection: edge[k] = trig_i[k] & ~trig_q[k] & en_i[k], with trig_q a registered copy of trig_i.
  - A source disabled at the moment of its edge never fires later, even if it is enabled while trig_i stays high.
  - trig_q follows trig_i regardless of en_i.
- any_edge = |edge.
- FSM states, encoded in state_o:
  - IDLE=0. If any_edge & ~disable_i & ~busy_i: go to FIRE and latch trig_src_o.
  - IDLE, rejected case: if any_edge & (disable_i | busy_i), pulse lost_o for 1 cycle and stay in IDLE.
  - FIRE=1. trig_o=1 for exactly this cycle. Load the holdoff counter with holdoff_i. Next state is HOLDOFF if holdoff_i != 0, otherwise IDLE.
  - HOLDOFF=2. The counter decrements each cycle. On the cycle it reads 1, go to IDLE, so dead time is exactly holdoff_i cycles.
  - holdoff_i is sampled only in FIRE; changes during HOLDOFF have no effect.
- Latency: an edge at trig_i in cycle n is registered as trig_q in cycle n+1. edge is combinational from the registered value. The FSM enters FIRE at the clock ending cycle n+1, so trig_o is high in cycle n+2.
- Edges arriving during FIRE or HOLDOFF are rejected: lost_o pulses and the lost counter increments.
- Simultaneous edges are one accept. trig_src_o = edge mask (full mask unless the optional feature is enabled). Each source counter whose bit is set increments by 1.
- Counters:
  - Per-source counters wrap modulo 2^CNT_W.
  - The lost counter saturates at 2^CNT_W-1.
  - Lost counts once per rejection cycle, not once per source.
- clr_i: clears all counters in the next cycle and has priority over a same-cycle increment. It does not affect the FSM or trig_src_o.
- disable_i or busy_i asserted during HOLDOFF: holdoff continues normally. The gate is checked only in IDLE.
- Reset asserted mid-HOLDOFF: immediately returns to IDLE with all outputs 0.
- The unused state encoding 3 recovers to IDLE on the next clock.

Optional Feature:
TRIG_SRC_PRIORITY_EN
- Defined: trig_src_o is one-hot, giving the lowest-index source in the edge mask. Only that source's counter increments on a simultaneous accept.
- Undefined: trig_src_o carries the full simultaneous edge mask, and every source in the mask has its counter incremented.

Test Plan:
1. Reset release with en_i=4'b1111, holdoff_i=0; rising edge on trig_i[1] in cycle n -> trig_o=1 in cycle n+2 only, trig_src_o=4'b0010, cnt_sel_i=1 reads 1.
2. holdoff_i=10; edge on src0, then an edge on src2 five cycles after trig_o -> src2 rejected, lost_o pulses once, lost count=1. A new edge on src2 exactly 11 cycles after trig_o (first IDLE cycle) -> accepted.
3. Same-cycle edges on src0 and src3 -> a single trig_o. Without the macro: trig_src_o=4'b1001 and both counters equal 1. With TRIG_SRC_PRIORITY_EN: trig_src_o=4'b0001 and only counter 0 equals 1.
4. en_i=4'b0000 while trig_i[2] rises, then en_i[2] set while the level stays high -> no trig_o and no lost_o.
5. busy_i=1 with an edge on src1 -> lost_o=1, no trig_o, lost count increments. Preload the lost counter to 2^32-1, then reject again -> stays 2^32-1.
6. clr_i in the same cycle as an accepted src0 trigger -> counter 0 reads 0. Assert rst_n_i=0 mid-holdoff -> state_o=0 and trig_o=0 immediately, without waiting for a clock.
